// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one physical-memory port between an icache and a dcache.
// A grant latches the winner's request; pmem is driven only from the latched copy until pmem_resp.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,

  input  logic [31:0]  i_pmem_address,
  input  logic         i_pmem_read,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,

  input  logic [31:0]  d_pmem_address,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,

  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  // state   | meaning
  // IDLE    | no transaction; arbitrate pending requests
  // SERVE_I | icache fill in flight on pmem
  // SERVE_D | dcache fill or writeback in flight on pmem
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [31:0]    addr_q, addr_d;
  logic           read_q, read_d;
  logic           write_q, write_d;
  logic [255:0]   wdata_q, wdata_d;

  logic           i_req;
  logic           d_req;
  logic           grant_d_side;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // On a tie the side not named by last_grant wins.
  always_comb begin
    grant_d_side = 1'b0;
    if (i_req && d_req) begin
      grant_d_side = ~last_grant_q;
    end else if (d_req) begin
      grant_d_side = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    read_d       = read_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && grant_d_side) begin
          state_d = SERVE_D;
          addr_d  = d_pmem_address;
          write_d = d_pmem_write;
          read_d  = d_pmem_read & ~d_pmem_write;
          wdata_d = d_pmem_wdata;
        end else if (i_req) begin
          state_d = SERVE_I;
          addr_d  = i_pmem_address;
          write_d = 1'b0;
          read_d  = 1'b1;
          wdata_d = '0;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
    end
  end

  // Outputs are also gated by rst so nothing leaks out before the reset edge lands.
  logic busy;
  assign busy = rst && (state_q != IDLE);

  assign pmem_address = rst ? addr_q  : '0;
  assign pmem_wdata   = rst ? wdata_q : '0;
  assign pmem_read    = busy & read_q & ~write_q;
  assign pmem_write   = busy & write_q;

  assign i_pmem_resp  = rst && (state_q == SERVE_I) && pmem_resp;
  assign d_pmem_resp  = rst && (state_q == SERVE_D) && pmem_resp;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed checks of cache_arbiter grant order, latching, reset abort, plus a bounded random stress run.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_read;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [31:0]  d_pmem_address;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  cache_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_address   (pmem_address),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick();
    tick();
    chk("rst_read",  pmem_read,    1'b0);
    chk("rst_write", pmem_write,   1'b0);
    chk("rst_addr",  pmem_address, 32'h0);
    chk("rst_wdata", pmem_wdata,   256'h0);
    chk("rst_iresp", i_pmem_resp,  1'b0);
    chk("rst_dresp", d_pmem_resp,  1'b0);
    rst = 1'b1;
    #1;
  endtask

  // stress-model state
  logic i_pend, d_pend, i_done, d_done, mem_active;
  int   mem_cnt, i_wait, d_wait, i_reqs, i_resps, d_reqs, d_resps;
  logic [255:0] r1;

  initial begin
    r1 = {8{32'h1234_ABCD}};

    // icache read alone, resp in 5th serve cycle
    do_reset();
    i_pmem_address = 32'h0000_0040; i_pmem_read = 1'b1;
    #1 chk("t1_idle_nostrobe", pmem_read, 1'b0);
    tick();
    chk("t1_read",  pmem_read,    1'b1);
    chk("t1_write", pmem_write,   1'b0);
    chk("t1_addr",  pmem_address, 32'h40);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_hold_read", pmem_read,   1'b1);
      chk("t1_no_iresp",  i_pmem_resp, 1'b0);
    end
    pmem_rdata = r1; pmem_resp = 1'b1;
    #1;
    chk("t1_iresp",     i_pmem_resp,  1'b1);
    chk("t1_dresp",     d_pmem_resp,  1'b0);
    chk("t1_irdata",    i_pmem_rdata, r1);
    chk("t1_drdata",    d_pmem_rdata, r1);
    chk("t1_read_last", pmem_read,    1'b1);
    tick();
    i_pmem_read = 1'b0; pmem_resp = 1'b0;
    #1;
    chk("t1_idle_read",  pmem_read,   1'b0);
    chk("t1_idle_iresp", i_pmem_resp, 1'b0);

    // tie out of reset: dcache, then icache, then dcache again
    do_reset();
    i_pmem_address = 32'h100; i_pmem_read = 1'b1;
    d_pmem_address = 32'h200; d_pmem_read = 1'b1;
    tick();
    chk("t2_first_d", pmem_address, 32'h200);
    chk("t2_read_d",  pmem_read,    1'b1);
    pmem_resp = 1'b1;
    #1;
    chk("t2_dresp", d_pmem_resp, 1'b1);
    chk("t2_iresp_quiet", i_pmem_resp, 1'b0);
    tick();
    d_pmem_read = 1'b0; pmem_resp = 1'b0;
    #1 chk("t2_idle_gap", pmem_read, 1'b0);
    tick();
    chk("t2_then_i", pmem_address, 32'h100);
    chk("t2_read_i", pmem_read,    1'b1);
    pmem_resp = 1'b1;
    #1;
    chk("t2_iresp", i_pmem_resp, 1'b1);
    chk("t2_dresp_quiet", d_pmem_resp, 1'b0);
    tick();
    i_pmem_read = 1'b0; pmem_resp = 1'b0;
    tick();
    i_pmem_address = 32'h140; i_pmem_read = 1'b1;
    d_pmem_address = 32'h240; d_pmem_read = 1'b1;
    tick();
    chk("t2_tie2_d", pmem_address, 32'h240);
    pmem_resp = 1'b1;
    tick();
    d_pmem_read = 1'b0; pmem_resp = 1'b0;
    tick();
    chk("t2_tie2_then_i", pmem_address, 32'h140);
    pmem_resp = 1'b1;
    tick();
    i_pmem_read = 1'b0; pmem_resp = 1'b0;
    tick();

    // dcache writeback; request inputs change mid-transaction
    d_pmem_address = 32'h0000_0080; d_pmem_write = 1'b1; d_pmem_wdata = {32{8'hA5}};
    tick();
    chk("t3_write", pmem_write,   1'b1);
    chk("t3_read",  pmem_read,    1'b0);
    chk("t3_addr",  pmem_address, 32'h80);
    chk("t3_wdata", pmem_wdata,   {32{8'hA5}});
    d_pmem_address = 32'h1234_5678; d_pmem_wdata = '0;
    i_pmem_address = 32'h999; i_pmem_read = 1'b1;
    tick();
    chk("t3_addr_held",  pmem_address, 32'h80);
    chk("t3_wdata_held", pmem_wdata,   {32{8'hA5}});
    chk("t3_write_held", pmem_write,   1'b1);
    i_pmem_read = 1'b0; pmem_resp = 1'b1;
    #1;
    chk("t3_dresp", d_pmem_resp, 1'b1);
    chk("t3_iresp", i_pmem_resp, 1'b0);
    tick();
    d_pmem_write = 1'b0; pmem_resp = 1'b0;
    tick();

    // read+write together is a write
    d_pmem_address = 32'hC0; d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    tick();
    chk("t4_write", pmem_write, 1'b1);
    chk("t4_read",  pmem_read,  1'b0);
    pmem_resp = 1'b1;
    tick();
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
    tick();

    // reset two cycles into SERVE_I, then a late pmem_resp
    i_pmem_address = 32'h300; i_pmem_read = 1'b1;
    tick();
    tick();
    chk("t5_serving", pmem_read, 1'b1);
    rst = 1'b0;
    #1 chk("t5_rst_gate", pmem_read, 1'b0);
    tick();
    rst = 1'b1; i_pmem_read = 1'b0;
    #1;
    chk("t5_read",  pmem_read,    1'b0);
    chk("t5_write", pmem_write,   1'b0);
    chk("t5_addr",  pmem_address, 32'h0);
    pmem_resp = 1'b1;
    #1;
    chk("t5_late_iresp", i_pmem_resp, 1'b0);
    chk("t5_late_dresp", d_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    #1 chk("t5_still_idle", pmem_read, 1'b0);

    // random stress with 1-20 cycle memory latency
    i_pend = 0; d_pend = 0; i_done = 0; d_done = 0; mem_active = 0; mem_cnt = 0;
    i_wait = 0; d_wait = 0; i_reqs = 0; i_resps = 0; d_reqs = 0; d_resps = 0;
    for (int cyc = 0; cyc < 10200; cyc++) begin
      @(posedge clk);
      #1;
      if (i_done) begin
        i_pmem_read = 1'b0; i_pend = 0; i_done = 0;
      end else if (!i_pend && cyc < 10000 && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_wait = 0; i_reqs++;
        i_pmem_read = 1'b1; i_pmem_address = $urandom;
      end
      if (d_done) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pend = 0; d_done = 0;
      end else if (!d_pend && cyc < 10000 && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_wait = 0; d_reqs++;
        d_pmem_address = $urandom; d_pmem_wdata = {8{$urandom}};
        d_pmem_write = 1'($urandom_range(0, 1));
        d_pmem_read  = ~d_pmem_write | 1'($urandom_range(0, 1));
      end
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (!mem_active) begin
          mem_active = 1; mem_cnt = $urandom_range(0, 19);
        end
        if (mem_cnt == 0) begin
          pmem_resp = 1'b1; pmem_rdata = {8{$urandom}}; mem_active = 0;
        end else begin
          mem_cnt--;
        end
      end
      @(negedge clk);
      if (pmem_read && pmem_write) chk("st_overlap", {pmem_read, pmem_write}, 2'b10);
      if (i_pmem_resp) begin
        chk("st_iresp_pending", i_pend, 1'b1);
        chk("st_iresp_excl",    d_pmem_resp, 1'b0);
        i_done = 1; i_resps++;
        if (d_pend) begin
          d_wait++;
          chk("st_d_starve", 1'(d_wait > 1), 1'b0);
        end
      end
      if (d_pmem_resp) begin
        chk("st_dresp_pending", d_pend, 1'b1);
        d_done = 1; d_resps++;
        if (i_pend) begin
          i_wait++;
          chk("st_i_starve", 1'(i_wait > 1), 1'b0);
        end
      end
    end
    chk("st_i_all_served", 1'(i_pend | i_done), 1'b0);
    chk("st_d_all_served", 1'(d_pend | d_done), 1'b0);
    chk("st_i_count", i_resps, i_reqs);
    chk("st_d_count", d_resps, d_reqs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
